pixel_packer: RTL
=================

# pixel_packer

- Downstream stage of the display controller: consumes the serial colour-byte stream the controller steers through its R/G/B/blank selects.
- Reassembles each R→G→B triplet, or blank triplet, into one registered 24-bit pixel with a valid strobe.
- Stretches the controller's single-cycle SyncHB/SyncVB pulses into HSync/VSync outputs and keeps pixel/line position counters.
- Flags any select sequence that breaks R→G→B phase order; feeds the panel/DAC interface.

## Interface
Parameters:
- COLOR_W, 8, bits per colour component
- CNT_W, 10, width of pixel/line counters
- HSYNC_W, 4, HSync stretch length in clk cycles (≥1)
- VSYNC_W, 8, VSync stretch length in clk cycles (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- CSDisplay  in  1  display enable; low = idle/flush
- ColorIn  in  COLOR_W  colour byte from buffer mux, valid in the SelR/SelG/SelB cycle
- SelR, SelG, SelB  in  1  component strobes (expected one-hot with SelBlank)
- SelBlank  in  1  blanking slot
- SyncHB, SyncVB  in  1  single-cycle line/frame start pulses
- PixelOut  out  3*COLOR_W  {R,G,B}; zero for blank pixels
- PixelValid  out  1  one-cycle strobe per completed pixel
- BlankOut  out  1  qualifies PixelValid as a blank pixel
- HSync, VSync  out  1  stretched sync outputs, active-high
- PxCount, LineCount  out  CNT_W  position of the last emitted pixel
- PhaseErr  out  1  one-cycle pulse on a phase violation

## Operation
- Phase FSM with states IDLE, PH_R, PH_G, PH_B. IDLE→PH_R when CSDisplay=1. Any state→IDLE when CSDisplay=0.
- A cycle with SyncHB or SyncVB counts as the R slot of a new triplet. The next state is PH_G, and the triplet is blank.
- In PH_R: SelR captures R, SelBlank marks blank; → PH_G.
- In PH_G: SelG captures G, or SelBlank; → PH_B.
- In PH_B: SelB captures B, or SelBlank. The pixel is emitted, → PH_R.
- A triplet is blank if any of its slots was SelBlank or sync. Blank pixels have PixelOut=0 and BlankOut=1.
- Phase violations: wrong strobe for the current phase, more than one of SelR/SelG/SelB/SelBlank high, or no strobe at all outside IDLE.
  - On a violation, PhaseErr pulses and the FSM realigns to the strobe seen: SelR→PH_G, SelG→PH_B, SelB→emit→PH_R.
  - If no strobe was seen, the FSM holds its phase.
- Counters:
  - PxCount increments on each emitted pixel and wraps at 2^CNT_W.
  - SyncHB clears PxCount and increments LineCount, which also wraps.
  - SyncVB clears both counters.
  - SyncHB and SyncVB in the same cycle: SyncVB wins.
- Sync stretch:
  - SyncHB loads an HSync down-counter with HSYNC_W; likewise SyncVB with VSYNC_W.
  - A retrigger while active reloads the counter (no pulse merging beyond reload).
- CSDisplay=0: FSM to IDLE, partial triplet discarded, counters cleared, PixelValid/HSync/VSync forced low next cycle.
- Reset values: every output 0, FSM IDLE, all registers 0.

## Timing
- Pixel latency is 1 cycle: PixelValid/PixelOut/BlankOut are registered in the cycle after the B-slot cycle.
- PixelOut holds its value until the next PixelValid.
- Steady state: one pixel every 3 cycles.
- HSync/VSync rise 1 cycle after the sync input and stay high exactly HSYNC_W/VSYNC_W cycles.
- PxCount/LineCount update in the same cycle as PixelValid and sync, respectively.
- PhaseErr is registered and appears 1 cycle after the offending input.
- Reset mid-triplet: outputs drop immediately on reset assertion. After release, the FSM restarts in IDLE.

## Configuration
- FRAME_CHECK_EN defined:
  - Adds LineLenErr (out, 1) and ErrCount (out, 8).
  - On each SyncHB, the completed line's PxCount is compared with the previous line's; a mismatch pulses LineLenErr 1 cycle later.
  - The first line after SyncVB or CSDisplay rise is not checked.
  - ErrCount increments, saturating at 255, on every PhaseErr or LineLenErr; it clears only on reset.
- FRAME_CHECK_EN undefined: those ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package display_pkg:
  - phase enum (IDLE/PH_R/PH_G/PH_B)
  - COLOR_W/CNT_W defaults
  - pixel struct {r,g,b}
- Sub-module sync_stretch: parameterised width, with trigger in and level out; instantiated twice, for HSync and VSync.

## Test plan
- Reset, CSDisplay=1, SelR/SelG/SelB with ColorIn 0x11,0x22,0x33 → PixelValid one cycle after SelB, PixelOut=0x112233, BlankOut=0, PxCount=1.
- SyncVB, then SelBlank ×2 → blank pixel: PixelOut=0, BlankOut=1, PxCount=1, LineCount=0. VSync is high for 8 cycles starting 1 cycle after SyncVB.
- 4 pixels, SyncHB, 4 pixels → PxCount reaches 4, then clears to 0 on SyncHB and ends at 4; LineCount=1; HSync high 4 cycles.
- SelR then SelB (G missing) → PhaseErr pulse; pixel emitted with the stale G, FSM in PH_R; next clean triplet correct.
- CSDisplay dropped after SelR → no PixelValid, counters 0; re-enable and a clean triplet yields a correct pixel.
- FRAME_CHECK_EN: lines of 5 then 6 pixels → LineLenErr pulse 1 cycle after the second SyncHB, ErrCount=1.

Source files
------------

// File: rtl/display_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared types and defaults for the display pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int COLOR_W_DEF = 8;
    localparam int CNT_W_DEF   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_R = 2'd1,
        PH_G = 2'd2,
        PH_B = 2'd3
    } phase_t;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } pixel_t;

endpackage

`default_nettype wire

// File: rtl/pixel_packer_if.sv
// ============================================================================
// Module      : pixel_packer_if
// Description : Colour-stream and panel-side signal bundle for pixel_packer.
//               LineLenErr/ErrCount exist only when FRAME_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_packer_if
    import display_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic                 CSDisplay;
    logic [COLOR_W-1:0]   ColorIn;
    logic                 SelR;
    logic                 SelG;
    logic                 SelB;
    logic                 SelBlank;
    logic                 SyncHB;
    logic                 SyncVB;
    logic [3*COLOR_W-1:0] PixelOut;
    logic                 PixelValid;
    logic                 BlankOut;
    logic                 HSync;
    logic                 VSync;
    logic [CNT_W-1:0]     PxCount;
    logic [CNT_W-1:0]     LineCount;
    logic                 PhaseErr;
`ifdef FRAME_CHECK_EN
    logic                 LineLenErr;
    logic [7:0]           ErrCount;
`endif

    modport master (
        output CSDisplay, ColorIn, SelR, SelG, SelB, SelBlank, SyncHB, SyncVB,
`ifdef FRAME_CHECK_EN
        input  LineLenErr, ErrCount,
`endif
        input  PixelOut, PixelValid, BlankOut, HSync, VSync, PxCount, LineCount, PhaseErr
    );

    modport slave (
        input  CSDisplay, ColorIn, SelR, SelG, SelB, SelBlank, SyncHB, SyncVB,
`ifdef FRAME_CHECK_EN
        output LineLenErr, ErrCount,
`endif
        output PixelOut, PixelValid, BlankOut, HSync, VSync, PxCount, LineCount, PhaseErr
    );

endinterface

`default_nettype wire

// File: rtl/sync_stretch.sv
// ============================================================================
// Module      : sync_stretch
// Description : Stretches a single-cycle trigger into a LEN-cycle level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_stretch #(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_trig,
    output logic o_level
);
    localparam int c_CW = $clog2(LEN + 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_trig) begin
            r_cnt <= c_CW'(LEN);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CW'(1);
        end
    end

    assign o_level = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/pixel_packer.sv
// ============================================================================
// Module      : pixel_packer
// Description : Reassembles R/G/B colour slots into 24-bit pixels, stretches
//               syncs, tracks position. Optional FRAME_CHECK_EN adds line checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_packer
    import display_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int HSYNC_W = 4,
    parameter int VSYNC_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    pixel_packer_if.slave bus
);
    phase_t               r_phase, w_next;
    logic [COLOR_W-1:0]   r_r, r_g, r_b;
    logic                 r_blank, w_blank;
    logic                 w_cap_r, w_cap_g, w_cap_b, w_emit, w_err;
    logic [3*COLOR_W-1:0] r_pixel;
    logic                 r_valid, r_blank_out, r_phase_err;
    logic [CNT_W-1:0]     r_px, r_line;
    logic                 w_sync, w_legal, w_slot_strobe, w_hsync, w_vsync;

    assign w_sync = bus.SyncHB | bus.SyncVB;

    always_comb begin
        case (r_phase)
            PH_R:    w_slot_strobe = bus.SelR;
            PH_G:    w_slot_strobe = bus.SelG;
            PH_B:    w_slot_strobe = bus.SelB;
            default: w_slot_strobe = 1'b0;
        endcase
    end

    assign w_legal = $onehot({bus.SelR, bus.SelG, bus.SelB, bus.SelBlank})
                     && (bus.SelBlank || w_slot_strobe);

    always_comb begin
        w_next  = r_phase;
        w_blank = r_blank;
        w_cap_r = 1'b0;
        w_cap_g = 1'b0;
        w_cap_b = 1'b0;
        w_emit  = 1'b0;
        w_err   = 1'b0;
        if (!bus.CSDisplay) begin
            w_next = IDLE;
        end else if (w_sync) begin
            // a sync cycle occupies the R slot of a fresh, blank triplet
            w_next  = PH_G;
            w_blank = 1'b1;
        end else if (r_phase == IDLE) begin
            w_next = PH_R;
        end else if (w_legal) begin
            case (r_phase)
                PH_R: begin
                    w_cap_r = bus.SelR;
                    w_blank = bus.SelBlank;
                    w_next  = PH_G;
                end
                PH_G: begin
                    w_cap_g = bus.SelG;
                    w_blank = r_blank | bus.SelBlank;
                    w_next  = PH_B;
                end
                default: begin
                    w_cap_b = bus.SelB;
                    w_blank = r_blank | bus.SelBlank;
                    w_emit  = 1'b1;
                    w_next  = PH_R;
                end
            endcase
        end else begin
            // realign to the strobe actually seen; with no strobe hold phase
            w_err = 1'b1;
            if (bus.SelR) begin
                w_cap_r = 1'b1;
                w_blank = bus.SelBlank;
                w_next  = PH_G;
            end else if (bus.SelG) begin
                w_cap_g = 1'b1;
                w_blank = ((r_phase == PH_R) ? 1'b0 : r_blank) | bus.SelBlank;
                w_next  = PH_B;
            end else if (bus.SelB) begin
                w_cap_b = 1'b1;
                w_blank = ((r_phase == PH_R) ? 1'b0 : r_blank) | bus.SelBlank;
                w_emit  = 1'b1;
                w_next  = PH_R;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase     <= IDLE;
            r_blank     <= 1'b0;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_pixel     <= '0;
            r_valid     <= 1'b0;
            r_blank_out <= 1'b0;
            r_phase_err <= 1'b0;
            r_px        <= '0;
            r_line      <= '0;
        end else begin
            r_phase     <= w_next;
            r_blank     <= w_blank;
            r_valid     <= w_emit;
            r_phase_err <= w_err;
            if (w_cap_r) r_r <= bus.ColorIn;
            if (w_cap_g) r_g <= bus.ColorIn;
            if (w_cap_b) r_b <= bus.ColorIn;
            if (w_emit) begin
                r_pixel     <= w_blank ? '0 : {r_r, r_g, (w_cap_b ? bus.ColorIn : r_b)};
                r_blank_out <= w_blank;
            end
            if (!bus.CSDisplay || bus.SyncVB) begin
                r_px   <= '0;
                r_line <= '0;
            end else if (bus.SyncHB) begin
                r_px   <= '0;
                r_line <= r_line + CNT_W'(1);
            end else if (w_emit) begin
                r_px <= r_px + CNT_W'(1);
            end
        end
    end

    sync_stretch #(.LEN(HSYNC_W)) u_hsync (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!bus.CSDisplay),
        .i_trig  (bus.SyncHB),
        .o_level (w_hsync)
    );

    sync_stretch #(.LEN(VSYNC_W)) u_vsync (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!bus.CSDisplay),
        .i_trig  (bus.SyncVB),
        .o_level (w_vsync)
    );

`ifdef FRAME_CHECK_EN
    logic [CNT_W-1:0] r_prev_len;
    logic             r_have_prev, r_len_err, w_len_err;
    logic [7:0]       r_err_cnt;

    assign w_len_err = bus.CSDisplay && bus.SyncHB && !bus.SyncVB
                       && r_have_prev && (r_px != r_prev_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_len  <= '0;
            r_have_prev <= 1'b0;
            r_len_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_len_err <= w_len_err;
            if (!bus.CSDisplay || bus.SyncVB) begin
                r_have_prev <= 1'b0;
            end else if (bus.SyncHB) begin
                r_have_prev <= 1'b1;
                r_prev_len  <= r_px;
            end
            if ((w_err || w_len_err) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.LineLenErr = r_len_err;
    assign bus.ErrCount   = r_err_cnt;
`endif

    assign bus.PixelOut   = r_pixel;
    assign bus.PixelValid = r_valid;
    assign bus.BlankOut   = r_blank_out;
    assign bus.PhaseErr   = r_phase_err;
    assign bus.PxCount    = r_px;
    assign bus.LineCount  = r_line;
    assign bus.HSync      = w_hsync;
    assign bus.VSync      = w_vsync;

endmodule

`default_nettype wire
